cipher_core: RTL and testbench

- Parametrised, iterative AES forward cipher: encrypts one 128-bit block per transaction using an already-expanded key schedule.
- Supports AES-128/192/256 through `Nk`; one round per clock.
- Replaces the fixed free-running encryption sequencer with valid/ready handshakes on both sides, captured operands and a held result.
- Sits between the key-expansion block and the mode/stream logic; round datapath built from the existing SubBytes, shift_rows, mix-columns and AddRoundKey blocks.

---
 rtl/cipher_core.sv | 187 ++++++++++++++++++
 tb/tb_cipher_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cipher_core                                                  |
// | Description : Iterative AES forward cipher, one round per clock, working   |
// |               from a pre-expanded key schedule (AES-128/192/256 via Nk).   |
// |               Valid/ready on both sides, operands captured on accept,      |
// |               single-entry output slot holding the ciphertext.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clks          in   1              rising-edge clock                      |
// |   reset         in   1              asynchronous, active-low reset         |
// |   in_valid      in   1              plaintext + schedule presented         |
// |   in_ready      out  1              core idle, will accept                 |
// |   plainText     in   128            input block, AES byte 0 in [127:120]   |
// |   keys          in   128*(Nr+1)     round key r at [128*r +: 128]          |
// |   out_valid     out  1              encryptedText holds a result           |
// |   out_ready     in   1              consumer takes the result              |
// |   encryptedText out  128            ciphertext (registered)                |
// |   busy          out  1              sequencer outside IDLE                 |
// |   round_idx     out  4              current round counter (debug)          |
// +----------------------------------------------------------------------------+
module cipher_core #(
  parameter  int Nk = 4,
  localparam int Nr = Nk + 6
) (
  input  logic                  clks,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          plainText,
  input  logic [128*(Nr+1)-1:0] keys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          encryptedText,
  output logic                  busy,
  output logic [3:0]            round_idx
);

  generate
    if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
      $error("cipher_core: Nk must be 4, 6 or 8");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(Nr - 1);

  // Forward S-box; entry x lives at bits [(255-x)*8 +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUNDS = 2'd1,
    FINAL  = 2'd2
  } fsm_e;

  // Byte n of the AES state sits at [127-8n -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{8'd255 - x, 3'd0} +: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  fsm_e                  fsm_q, fsm_d;
  logic [127:0]          blk_q, blk_d;
  logic [128*(Nr+1)-1:0] sched_q, sched_d;
  logic [3:0]            round_idx_q, round_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [127:0]          ct_q, ct_d;

  logic [127:0] round_key;
  logic [127:0] shifted;
  logic [127:0] round_out;
  logic [127:0] final_out;
  logic         slot_free;

  // round_idx doubles as the key selector: in FINAL it equals Nr, so the
  // same mux serves both the middle rounds and the last one.
  assign round_key = sched_q[{round_idx_q, 7'd0} +: 128];
  assign shifted   = shift_rows(sub_bytes(blk_q));
  assign round_out = mix_columns(shifted) ^ round_key;
  assign final_out = shifted ^ round_key;

  // The slot can take a new result if empty or being drained this cycle.
  assign slot_free = ~out_valid_q | out_ready;

  always_comb begin
    fsm_d       = fsm_q;
    blk_d       = blk_q;
    sched_d     = sched_q;
    round_idx_d = round_idx_q;
    out_valid_d = out_valid_q & ~out_ready;
    ct_d        = ct_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          sched_d     = keys;
          blk_d       = plainText ^ keys[127:0];
          round_idx_d = 4'd1;
          fsm_d       = ROUNDS;
        end
      end
      ROUNDS: begin
        blk_d       = round_out;
        round_idx_d = round_idx_q + 4'd1;
        if (round_idx_q == LAST_ROUND) fsm_d = FINAL;
      end
      FINAL: begin
        // Reload wins over a simultaneous drain, keeping out_valid high.
        if (slot_free) begin
          ct_d        = final_out;
          out_valid_d = 1'b1;
          round_idx_d = 4'd0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clks or negedge reset) begin
    if (!reset) begin
      fsm_q       <= IDLE;
      blk_q       <= '0;
      sched_q     <= '0;
      round_idx_q <= 4'd0;
      out_valid_q <= 1'b0;
      ct_q        <= '0;
    end else begin
      fsm_q       <= fsm_d;
      blk_q       <= blk_d;
      sched_q     <= sched_d;
      round_idx_q <= round_idx_d;
      out_valid_q <= out_valid_d;
      ct_q        <= ct_d;
    end
  end

  assign in_ready      = (fsm_q == IDLE);
  assign busy          = (fsm_q != IDLE);
  assign out_valid     = out_valid_q;
  assign encryptedText = ct_q;
  assign round_idx     = round_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cipher_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cipher_core                                               |
// | Description : Self-checking bench for cipher_core: known-answer vectors    |
// |               for AES-128/192/256, mid-block reset, backpressure and       |
// |               randomized traffic against a byte-level AES reference.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cipher_core;

  localparam int W4 = 128 * 11;
  localparam int W6 = 128 * 13;
  localparam int W8 = 128 * 15;
  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

  logic clks = 1'b0;
  always #5 clks = ~clks;

  logic          reset;
  logic          iv4, iv68, or4, or68;
  logic [127:0]  pt4, pt68;
  logic [W4-1:0] keys4;
  logic [W6-1:0] keys6;
  logic [W8-1:0] keys8;
  logic [2:0]    ov, ir, bz;
  logic [3:0]    ri [3];
  logic [127:0]  ct [3];

  cipher_core #(.Nk(4)) u_dut4 (
    .clks(clks), .reset(reset), .in_valid(iv4), .in_ready(ir[0]),
    .plainText(pt4), .keys(keys4), .out_valid(ov[0]), .out_ready(or4),
    .encryptedText(ct[0]), .busy(bz[0]), .round_idx(ri[0]));

  cipher_core #(.Nk(6)) u_dut6 (
    .clks(clks), .reset(reset), .in_valid(iv68), .in_ready(ir[1]),
    .plainText(pt68), .keys(keys6), .out_valid(ov[1]), .out_ready(or68),
    .encryptedText(ct[1]), .busy(bz[1]), .round_idx(ri[1]));

  cipher_core #(.Nk(8)) u_dut8 (
    .clks(clks), .reset(reset), .in_valid(iv68), .in_ready(ir[2]),
    .plainText(pt68), .keys(keys8), .out_valid(ov[2]), .out_ready(or68),
    .encryptedText(ct[2]), .busy(bz[2]), .round_idx(ri[2]));

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // ---------------- reference AES (GF arithmetic, byte arrays) ----------------
  logic [7:0] sbt [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbt[v[31:24]], sbt[v[23:16]], sbt[v[15:8]], sbt[v[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1919:0] sch;
    int            nw;
    nw = 4 * (nk + 7); rc = 8'h01; sch = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < nw; i++) sch[128*(i/4) + 127 - 32*(i%4) -: 32] = w[i];
    return sch;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1919:0] sch, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ sch[127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) u[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = u[4*((c+r)%4)+r];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ sch[128*rnd + 127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [1919:0] rand_w();
    logic [1919:0] v;
    for (int i = 0; i < 60; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // -------- transaction-level timing model for the Nk=4 instance --------
  int           t;
  int           acc_edge;
  int           done_edge;
  logic         m_have;
  logic         m_slot_valid;
  logic [127:0] m_blk_ct;
  logic [127:0] m_slot_ct;
  logic         last_acc;

  task automatic tick();
    @(posedge clks);
    #1;
    t++;
  endtask

  // A block accepted at edge A is ready at A+10 and enters the slot at the
  // first edge from then on where the slot is empty or being drained.
  task automatic step();
    int   tn;
    int   exp_ri;
    logic cons, emit, acc;
    tn   = t + 1;
    cons = m_slot_valid && or4;
    emit = m_have && (tn >= done_edge) && (!m_slot_valid || or4);
    acc  = iv4 && !m_have;
    if (emit) begin
      m_slot_valid = 1'b1;
      m_slot_ct    = m_blk_ct;
      m_have       = 1'b0;
    end else if (cons) begin
      m_slot_valid = 1'b0;
    end
    if (acc) begin
      m_have    = 1'b1;
      acc_edge  = tn;
      done_edge = tn + 10;
      m_blk_ct  = aes_ref(pt4, {512'b0, keys4}, 10);
    end
    last_acc = acc;
    tick();
    exp_ri = m_have ? (((t - acc_edge + 1) < 10) ? (t - acc_edge + 1) : 10) : 0;
    check($sformatf("e%0d_in_ready", t), 128'(ir[0]), 128'(!m_have));
    check($sformatf("e%0d_busy", t), 128'(bz[0]), 128'(m_have));
    check($sformatf("e%0d_out_valid", t), 128'(ov[0]), 128'(m_slot_valid));
    check($sformatf("e%0d_ct", t), ct[0], m_slot_ct);
    check($sformatf("e%0d_round_idx", t), 128'(ri[0]), 128'(exp_ri));
  endtask

  initial begin
    logic [1919:0] s4, s6, s8, rnd, rnd2;
    logic [255:0]  kk;
    logic [7:0]    p;
    int            nr_tab [3];
    logic [127:0]  kat_ct [3];
    int            nr;
    int            bp_acc;

    n_checks = 0; n_pass = 0; t = 0;
    acc_edge = 0; done_edge = 0; last_acc = 1'b0;
    m_have = 1'b0; m_slot_valid = 1'b0; m_blk_ct = '0; m_slot_ct = '0;
    nr_tab = '{10, 12, 14};
    kat_ct = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               128'hdda97ca4864cdfe06eaf70a0ec0d7191,
               128'h8ea2b7ca516745bfeafc49904b496089};

    // S-box from the multiplicative inverse (x^254) and the affine map
    for (int x = 0; x < 256; x++) begin
      p = 8'h01;
      for (int j = 0; j < 254; j++) p = gmul(p, 8'(x));
      sbt[x] = p ^ rol8(p, 1) ^ rol8(p, 2) ^ rol8(p, 3) ^ rol8(p, 4) ^ 8'h63;
    end
    for (int b = 0; b < 32; b++) kk[255-8*b -: 8] = 8'(b);
    s4 = expand(kk, 4);
    s6 = expand(kk, 6);
    s8 = expand(kk, 8);

    reset = 1'b0; iv4 = 1'b0; iv68 = 1'b0; or4 = 1'b1; or68 = 1'b1;
    pt4 = '0; pt68 = '0; keys4 = '0; keys6 = '0; keys8 = '0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_out_valid", i), 128'(ov[i]), 128'(1'b0));
      check($sformatf("rst%0d_in_ready", i), 128'(ir[i]), 128'(1'b1));
      check($sformatf("rst%0d_busy", i), 128'(bz[i]), 128'(1'b0));
      check($sformatf("rst%0d_round_idx", i), 128'(ri[i]), 128'(0));
      check($sformatf("rst%0d_ct", i), ct[i], 128'(0));
    end
    #2 reset = 1'b1;

    // ---- known answers for all three key sizes, inputs scrambled after accept ----
    iv4 = 1'b1; iv68 = 1'b1; pt4 = KAT_PT; pt68 = KAT_PT;
    keys4 = s4[W4-1:0]; keys6 = s6[W6-1:0]; keys8 = s8;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("kat%0d_A_round_idx", i), 128'(ri[i]), 128'(1));
      check($sformatf("kat%0d_A_busy", i), 128'(bz[i]), 128'(1'b1));
      check($sformatf("kat%0d_A_in_ready", i), 128'(ir[i]), 128'(1'b0));
    end
    iv4 = 1'b0; iv68 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      rnd = rand_w(); rnd2 = rand_w();
      pt4 = rnd[127:0]; pt68 = rnd[255:128];
      keys4 = rnd[W4-1:0]; keys6 = rnd2[W6-1:0]; keys8 = rand_w();
      tick();
      for (int i = 0; i < 3; i++) begin
        nr = nr_tab[i];
        check($sformatf("kat%0d_out_valid_A+%0d", i, k), 128'(ov[i]), 128'(k == nr));
        check($sformatf("kat%0d_in_ready_A+%0d", i, k), 128'(ir[i]), 128'(k >= nr));
        check($sformatf("kat%0d_busy_A+%0d", i, k), 128'(bz[i]), 128'(k < nr));
        check($sformatf("kat%0d_round_idx_A+%0d", i, k), 128'(ri[i]), 128'((k < nr) ? k + 1 : 0));
        if (k == nr) check($sformatf("kat%0d_ct", i), ct[i], kat_ct[i]);
      end
    end

    // ---- reset in the middle of a block ----
    iv4 = 1'b1; pt4 = KAT_PT; keys4 = s4[W4-1:0];
    tick();
    iv4 = 1'b0;
    repeat (4) tick();
    check("mid_busy_before_reset", 128'(bz[0]), 128'(1'b1));
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(ov[0]), 128'(1'b0));
    check("mid_rst_in_ready", 128'(ir[0]), 128'(1'b1));
    check("mid_rst_busy", 128'(bz[0]), 128'(1'b0));
    check("mid_rst_round_idx", 128'(ri[0]), 128'(0));
    check("mid_rst_ct", ct[0], 128'(0));
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("post_rst_in_ready", 128'(ir[0]), 128'(1'b1));
    check("post_rst_out_valid", 128'(ov[0]), 128'(1'b0));
    m_have = 1'b0; m_slot_valid = 1'b0; m_slot_ct = '0;
    iv4 = 1'b1; or4 = 1'b1; pt4 = KAT_PT; keys4 = s4[W4-1:0];
    step();
    iv4 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      rnd = rand_w(); pt4 = rnd[127:0]; keys4 = rnd[W4-1:0];
      step();
      if (k == 10) begin
        check("post_rst_kat_out_valid", 128'(ov[0]), 128'(1'b1));
        check("post_rst_kat_ct", ct[0], kat_ct[0]);
      end
    end

    // ---- backpressure: two blocks back-to-back, consumer stalled 30 cycles ----
    or4 = 1'b0; bp_acc = 0;
    rnd = rand_w(); pt4 = rnd[127:0]; rnd = rand_w(); keys4 = rnd[W4-1:0]; iv4 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (last_acc) begin
        bp_acc++;
        if (bp_acc == 1) begin
          rnd = rand_w(); pt4 = rnd[127:0]; rnd = rand_w(); keys4 = rnd[W4-1:0];
        end else begin
          iv4 = 1'b0;
        end
      end
    end
    iv4 = 1'b0; or4 = 1'b1;
    repeat (20) step();

    // ---- randomized traffic with three levels of consumer readiness ----
    for (int seg = 0; seg < 3; seg++) begin
      for (int c = 0; c < 250; c++) begin
        if (!iv4) begin
          rnd = rand_w(); keys4 = rnd[W4-1:0];
          rnd = rand_w(); pt4 = rnd[127:0];
          iv4 = ($urandom_range(0, 1) == 1);
        end
        case (seg)
          0:       or4 = ($urandom_range(0, 3) == 0);
          1:       or4 = ($urandom_range(0, 3) != 0);
          default: or4 = 1'b1;
        endcase
        step();
        if (last_acc) iv4 = 1'b0;
      end
    end
    iv4 = 1'b0; or4 = 1'b1;
    repeat (15) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
